// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds dispatched micro-ops, captures operands from
// several CDB ports and issues the oldest fully-ready entry each cycle.
module issue_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CDB_PORTS = 2,
   parameter int unsigned ROB_W     = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned OP_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           dis_valid,
   output logic                           dis_ready,
   input  logic [OP_W-1:0]                dis_op,
   input  logic [ROB_W-1:0]               dis_dest,
   input  logic [1:0]                     dis_src_rdy,
   input  logic [2*ROB_W-1:0]             dis_src_tag,
   input  logic [2*DATA_W-1:0]            dis_src_val,
   input  logic [CDB_PORTS-1:0]           cdb_valid,
   input  logic [CDB_PORTS*ROB_W-1:0]     cdb_tag,
   input  logic [CDB_PORTS*DATA_W-1:0]    cdb_data,
   output logic                           iss_valid,
   input  logic                           iss_ready,
   output logic [OP_W-1:0]                iss_op,
   output logic [ROB_W-1:0]               iss_dest,
   output logic [DATA_W-1:0]              iss_src1,
   output logic [DATA_W-1:0]              iss_src2,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned RANK_W = $clog2(DEPTH);
   localparam int unsigned IDX_W  = $clog2(DEPTH);

   // Per-entry state; rank 0 is the oldest valid entry, ranks are dense.
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [RANK_W-1:0]  rank_q [DEPTH];
   logic [RANK_W-1:0]  rank_d [DEPTH];
   logic [OP_W-1:0]    op_q   [DEPTH];
   logic [OP_W-1:0]    op_d   [DEPTH];
   logic [ROB_W-1:0]   dest_q [DEPTH];
   logic [ROB_W-1:0]   dest_d [DEPTH];
   logic [1:0]         rdy_q  [DEPTH];
   logic [1:0]         rdy_d  [DEPTH];
   logic [ROB_W-1:0]   tag_q  [DEPTH][2];
   logic [ROB_W-1:0]   tag_d  [DEPTH][2];
   logic [DATA_W-1:0]  val_q  [DEPTH][2];
   logic [DATA_W-1:0]  val_d  [DEPTH][2];
   logic [CNT_W-1:0]   count_q, count_d;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [RANK_W-1:0]  sel_rank;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               dis_fire;
   logic               iss_fire;
   logic               hit;
   logic [DATA_W-1:0]  wk_data;
   logic [ROB_W-1:0]   src_tag;

   // Lowest-index CDB port carrying the given tag wins.
   function automatic logic cdb_match(input logic [ROB_W-1:0] tag,
                                      output logic [DATA_W-1:0] data);
      logic m;
      m    = 1'b0;
      data = '0;
      for (int p = 0; p < CDB_PORTS; p++) begin
         if (!m && cdb_valid[p] && (cdb_tag[p*ROB_W +: ROB_W] == tag)) begin
            m    = 1'b1;
            data = cdb_data[p*DATA_W +: DATA_W];
         end
      end
      return m;
   endfunction

   // Oldest ready entry by rank, and lowest free slot by index.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_rank   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (&rdy_q[i]) && (!sel_found || (rank_q[i] < sel_rank))) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_rank  = rank_q[i];
         end
         if (!vld_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign count     = count_q;
   assign dis_ready = (count_q < CNT_W'(DEPTH));
   assign iss_valid = sel_found && !flush;
   assign iss_fire  = iss_valid && iss_ready;
   assign dis_fire  = dis_valid && dis_ready && !flush;
   assign iss_op    = iss_valid ? op_q[sel_idx]      : '0;
   assign iss_dest  = iss_valid ? dest_q[sel_idx]    : '0;
   assign iss_src1  = iss_valid ? val_q[sel_idx][0]  : '0;
   assign iss_src2  = iss_valid ? val_q[sel_idx][1]  : '0;

   // Next state: wakeup, then issue removal, then dispatch, with flush overriding.
   always_comb begin
      vld_d   = vld_q;
      rank_d  = rank_q;
      op_d    = op_q;
      dest_d  = dest_q;
      rdy_d   = rdy_q;
      tag_d   = tag_q;
      val_d   = val_q;
      count_d = count_q + CNT_W'(dis_fire) - CNT_W'(iss_fire);
      hit     = 1'b0;
      wk_data = '0;
      src_tag = '0;

      for (int i = 0; i < DEPTH; i++) begin
         for (int s = 0; s < 2; s++) begin
            hit = cdb_match(tag_q[i][s], wk_data);
            if (vld_q[i] && !rdy_q[i][s] && hit) begin
               rdy_d[i][s] = 1'b1;
               val_d[i][s] = wk_data;
            end
         end
      end

      if (iss_fire) begin
         vld_d[sel_idx] = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rank_q[i] > sel_rank)) begin
               rank_d[i] = rank_q[i] - RANK_W'(1);
            end
         end
      end

      if (dis_fire) begin
         vld_d[free_idx]  = 1'b1;
         rank_d[free_idx] = RANK_W'(count_q - CNT_W'(iss_fire));
         op_d[free_idx]   = dis_op;
         dest_d[free_idx] = dis_dest;
         for (int s = 0; s < 2; s++) begin
            src_tag               = dis_src_tag[s*ROB_W +: ROB_W];
            tag_d[free_idx][s]    = src_tag;
            rdy_d[free_idx][s]    = dis_src_rdy[s];
            val_d[free_idx][s]    = dis_src_val[s*DATA_W +: DATA_W];
            hit = cdb_match(src_tag, wk_data);
            if (!dis_src_rdy[s] && hit) begin
               rdy_d[free_idx][s] = 1'b1;
               val_d[free_idx][s] = wk_data;
            end
         end
      end

      if (flush) begin
         vld_d   = '0;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) rank_d[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rank_q[i] <= '0;
            op_q[i]   <= '0;
            dest_q[i] <= '0;
            rdy_q[i]  <= '0;
            for (int s = 0; s < 2; s++) begin
               tag_q[i][s] <= '0;
               val_q[i][s] <= '0;
            end
         end
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         rank_q  <= rank_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         rdy_q   <= rdy_d;
         tag_q   <= tag_d;
         val_q   <= val_d;
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: per-cycle vector table with an issue scoreboard,
// followed by a hand-driven asynchronous reset sequence.
module tb_issue_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        dis_valid;
   logic        dis_ready;
   logic [15:0] dis_op;
   logic [3:0]  dis_dest;
   logic [1:0]  dis_src_rdy;
   logic [7:0]  dis_src_tag;
   logic [63:0] dis_src_val;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_tag;
   logic [63:0] cdb_data;
   logic        iss_valid;
   logic        iss_ready;
   logic [15:0] iss_op;
   logic [3:0]  iss_dest;
   logic [31:0] iss_src1;
   logic [31:0] iss_src2;
   logic [3:0]  count;

   issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_op(dis_op), .dis_dest(dis_dest),
      .dis_src_rdy(dis_src_rdy), .dis_src_tag(dis_src_tag), .dis_src_val(dis_src_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [15:0] op;
      logic [3:0]  dest;
      logic [1:0]  srdy;
      logic [3:0]  t1, t2;
      logic [31:0] v1, v2;
      logic [1:0]  cv;
      logic [3:0]  ct0, ct1;
      logic [31:0] cd0, cd1;
      logic        ir, fl;
      logic [3:0]  ecnt;
      logic        eiv;
      logic [15:0] eop;
      logic [3:0]  edest;
      logic [31:0] es1, es2;
   } vec_t;

   typedef struct {
      logic [15:0] op;
      logic [3:0]  dest;
      logic [31:0] s1, s2;
   } iss_t;

   vec_t vecs[$];
   iss_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic row(input int dv, op, dest, srdy, t1, t2, v1, v2,
                      input int cv, ct0, cd0, ct1, cd1, ir, fl,
                      input int ecnt, eiv, eop, edest, es1, es2);
      vec_t r;
      r.dv = 1'(dv);   r.op = 16'(op);   r.dest = 4'(dest); r.srdy = 2'(srdy);
      r.t1 = 4'(t1);   r.t2 = 4'(t2);    r.v1 = 32'(v1);    r.v2 = 32'(v2);
      r.cv = 2'(cv);   r.ct0 = 4'(ct0);  r.cd0 = 32'(cd0);  r.ct1 = 4'(ct1); r.cd1 = 32'(cd1);
      r.ir = 1'(ir);   r.fl = 1'(fl);    r.ecnt = 4'(ecnt); r.eiv = 1'(eiv);
      r.eop = 16'(eop); r.edest = 4'(edest); r.es1 = 32'(es1); r.es2 = 32'(es2);
      vecs.push_back(r);
   endtask

   task automatic idle(input int ir, ecnt, eiv, eop, edest, es1, es2);
      row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0, ecnt, eiv, eop, edest, es1, es2);
   endtask

   task automatic apply(input vec_t r);
      dis_valid   = r.dv;
      dis_op      = r.op;
      dis_dest    = r.dest;
      dis_src_rdy = r.srdy;
      dis_src_tag = {r.t2, r.t1};
      dis_src_val = {r.v2, r.v1};
      cdb_valid   = r.cv;
      cdb_tag     = {r.ct1, r.ct0};
      cdb_data    = {r.cd1, r.cd0};
      iss_ready   = r.ir;
      flush       = r.fl;
   endtask

   initial begin
      vec_t z;
      iss_t e;
      z = '{default: '0};
      rst = 1'b0;
      apply(z);

      // basic dispatch -> issue next cycle
      idle(0, 0, 0, 0, 0, 0, 0);
      row(1, 'h12, 3, 3, 0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 1, 1, 'h12, 3, 5, 7);
      idle(0, 0, 0, 0, 0, 0, 0);
      // out-of-order wakeup via CDB port 1
      row(1, 'hA, 1, 2, 4, 0, 0, 'h22, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      row(1, 'hB, 2, 3, 0, 0, 'h33, 'h44, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      idle(1, 2, 1, 'hB, 2, 'h33, 'h44);
      row(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 'hBAD, 4, 'hDEAD, 1, 0, 1, 0, 0, 0, 0, 0);
      idle(1, 1, 1, 'hA, 1, 'hDEAD, 'h22);
      idle(0, 0, 0, 0, 0, 0, 0);
      // dispatch-cycle bypass from CDB port 0
      row(1, 'hC, 5, 1, 0, 6, 'h11, 0, 1, 6, 'h55, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 1, 1, 'hC, 5, 'h11, 'h55);
      idle(0, 0, 0, 0, 0, 0, 0);
      // fill to full, age beats slot index, full refuses dispatch during issue
      row(1, 'h20, 0, 3, 0, 0, 'h100, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 8; i++)
         row(1, 'h20 + i, i, 2, 9, 0, 0, 'h200 + i, 0, (i == 3) ? 9 : 0, 0, 0, 0, 0, 0,
             i, 1, 'h20, 0, 'h100, 'h200);
      row(1, 'h99, 9, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 'h20, 0, 'h100, 'h200);
      row(1, 'h98, 9, 3, 0, 0, 2, 2, 0, 0, 0, 0, 0, 1, 0, 8, 1, 'h20, 0, 'h100, 'h200);
      row(1, 'h30, 8, 3, 0, 0, 'h300, 'h301, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
      row(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h900, 0, 0, 0, 0, 8, 1, 'h30, 8, 'h300, 'h301);
      idle(0, 8, 1, 'h21, 1, 'h900, 'h201);
      for (int i = 1; i < 8; i++) idle(1, 9 - i, 1, 'h20 + i, i, 'h900, 'h200 + i);
      idle(1, 1, 1, 'h30, 8, 'h300, 'h301);
      idle(0, 0, 0, 0, 0, 0, 0);
      // simultaneous dispatch and issue keeps count
      row(1, 'h40, 1, 3, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row(1, 'h41, 2, 3, 0, 0, 3, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h40, 1, 1, 2);
      idle(1, 1, 1, 'h41, 2, 3, 4);
      idle(0, 0, 0, 0, 0, 0, 0);
      // flush with five entries and iss_ready high; dispatch in that cycle is dropped
      for (int i = 0; i < 5; i++)
         row(1, 'h50 + i, i, 3, 0, 0, i, i + 16, 0, 0, 0, 0, 0, 0, 0, i, (i > 0) ? 1 : 0, 'h50, 0, 0, 16);
      row(1, 'h5F, 7, 3, 0, 0, 8, 9, 1, 1, 'h77, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0);
      idle(1, 0, 0, 0, 0, 0, 0);
      idle(0, 0, 0, 0, 0, 0, 0);

      // reset state while held in reset
      repeat (2) @(negedge clk);
      chk("reset_count", -1, 32'(count), 0);
      chk("reset_dis_ready", -1, 32'(dis_ready), 1);
      chk("reset_iss_valid", -1, 32'(iss_valid), 0);
      rst = 1'b1;

      foreach (vecs[k]) begin
         @(posedge clk); #1;
         apply(vecs[k]);
         if (vecs[k].eiv) begin
            e.op = vecs[k].eop; e.dest = vecs[k].edest; e.s1 = vecs[k].es1; e.s2 = vecs[k].es2;
            sb.push_back(e);
         end
         @(negedge clk);
         chk("iss_valid", k, 32'(iss_valid), 32'(vecs[k].eiv));
         chk("count", k, 32'(count), 32'(vecs[k].ecnt));
         chk("dis_ready", k, 32'(dis_ready), 32'(vecs[k].ecnt != 4'd8));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("iss_op", k, 32'(iss_op), 32'(e.op));
            chk("iss_dest", k, 32'(iss_dest), 32'(e.dest));
            chk("iss_src1", k, iss_src1, e.s1);
            chk("iss_src2", k, iss_src2, e.s2);
         end
      end
      chk("scoreboard_empty", -1, 32'(sb.size()), 0);

      // asynchronous reset with two entries in flight
      z.dv = 1'b1; z.srdy = 2'b11; z.op = 16'h61; z.v1 = 32'h1; z.v2 = 32'h2;
      @(posedge clk); #1; apply(z);
      z.op = 16'h62;
      @(posedge clk); #1; apply(z);
      z = '{default: '0};
      @(posedge clk); #1; apply(z);
      @(negedge clk);
      chk("pre_reset_count", -2, 32'(count), 2);
      chk("pre_reset_iss_op", -2, 32'(iss_op), 32'h61);
      #2 rst = 1'b0;
      #1;
      chk("async_count", -3, 32'(count), 0);
      chk("async_dis_ready", -3, 32'(dis_ready), 1);
      chk("async_iss_valid", -3, 32'(iss_valid), 0);
      chk("async_iss_op", -3, 32'(iss_op), 0);
      chk("async_iss_src1", -3, iss_src1, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_count", -4, 32'(count), 0);
      chk("post_reset_iss_valid", -4, 32'(iss_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
